bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_bus_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-requester round-robin arbiter onto main RAM, CGA RAM and BIOS ROM
module bus_arbiter #(
  parameter bit BIOS_WP = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [19:0] m0_address,
  input  logic [7:0]  m0_wdata,
  input  logic        m0_we,
  output logic        m0_ack,
  output logic [7:0]  m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [19:0] m1_address,
  input  logic [7:0]  m1_wdata,
  input  logic        m1_we,
  output logic        m1_ack,
  output logic [7:0]  m1_rdata,
  output logic        m1_err,
  output logic [17:0] mem_address,
  output logic [7:0]  mem_data,
  output logic        mem_we,
  input  logic [7:0]  mem_q,
  output logic [12:0] cga_address,
  output logic [7:0]  cga_data,
  output logic        cga_we,
  input  logic [7:0]  cga_q,
  output logic [12:0] bios_address,
  input  logic [7:0]  bios_q
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_LATCH, S_DONE} state_t;
  typedef enum logic [1:0] {R_MEM, R_CGA, R_BIOS, R_UNMAPPED} region_t;

  state_t      state;
  state_t      state_next;
  region_t     region_r;
  logic        grant_r;
  logic        last_grant;
  logic        we_r;
  logic        grant_valid;
  logic        grant_pick;
  logic        granted_req;
  logic [19:0] sel_address;
  logic [7:0]  sel_wdata;
  logic        sel_we;
  logic [7:0]  rdata_next;
  logic        err_next;

  function automatic region_t decode(input logic [19:0] a);
    if (a[19:18] == 2'b00) return R_MEM;
    if (a[19:13] == 7'h5C) return R_CGA;
    if (a[19:13] == 7'h78) return R_BIOS;
    return R_UNMAPPED;
  endfunction

  // On a tie the requester that was not granted last wins.
  always_comb begin
    grant_valid = m0_req | m1_req;
    grant_pick  = (m0_req && m1_req) ? ~last_grant : m1_req;
    sel_address = grant_pick ? m1_address : m0_address;
    sel_wdata   = grant_pick ? m1_wdata : m0_wdata;
    sel_we      = grant_pick ? m1_we : m0_we;
    granted_req = grant_r ? m1_req : m0_req;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (grant_valid) state_next = S_ACCESS;
      S_ACCESS: state_next = S_LATCH;
      S_LATCH:  state_next = S_DONE;
      S_DONE:   if (!granted_req) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_we     = 1'b0;
    cga_we     = 1'b0;
    rdata_next = 8'hFF;
    err_next   = 1'b0;
    if (state == S_ACCESS && we_r) begin
      mem_we = (region_r == R_MEM);
      cga_we = (region_r == R_CGA);
    end
    case (region_r)
      R_MEM:  if (!we_r) rdata_next = mem_q;
      R_CGA:  if (!we_r) rdata_next = cga_q;
      R_BIOS: begin
        if (!we_r) rdata_next = bios_q;
        err_next = we_r && BIOS_WP;
      end
      default: err_next = 1'b1;
    endcase
  end

  // Downstream buses are loaded only when a grant is taken, so they hold between transactions.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant   <= 1'b1;
      grant_r      <= 1'b0;
      we_r         <= 1'b0;
      region_r     <= R_MEM;
      mem_address  <= '0;
      cga_address  <= '0;
      bios_address <= '0;
      mem_data     <= '0;
      cga_data     <= '0;
      m0_ack       <= 1'b0;
      m1_ack       <= 1'b0;
      m0_rdata     <= 8'hFF;
      m1_rdata     <= 8'hFF;
      m0_err       <= 1'b0;
      m1_err       <= 1'b0;
    end else begin
      if (state == S_IDLE && grant_valid) begin
        grant_r      <= grant_pick;
        last_grant   <= grant_pick;
        we_r         <= sel_we;
        region_r     <= decode(sel_address);
        mem_address  <= sel_address[17:0];
        cga_address  <= sel_address[12:0];
        bios_address <= sel_address[12:0];
        mem_data     <= sel_wdata;
        cga_data     <= sel_wdata;
      end
      if (state == S_LATCH) begin
        if (grant_r) begin
          m1_rdata <= rdata_next;
          m1_err   <= err_next;
        end else begin
          m0_rdata <= rdata_next;
          m0_err   <= err_next;
        end
      end
      m0_ack <= (state == S_DONE) && !grant_r && m0_req;
      m1_ack <= (state == S_DONE) && grant_r && m1_req;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized self-checking bench for bus_arbiter
module tb_bus_arbiter;
  localparam bit BIOS_WP_TB = 1'b1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [19:0] m0_address = '0, m1_address = '0;
  logic [7:0]  m0_wdata = '0, m1_wdata = '0;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [7:0]  m0_rdata, m1_rdata;
  logic [17:0] mem_address;
  logic [7:0]  mem_data, mem_q;
  logic        mem_we, cga_we;
  logic [12:0] cga_address, bios_address;
  logic [7:0]  cga_data, cga_q, bios_q;

  int total = 0;
  int bad = 0;
  int n_mem_we = 0;
  int n_cga_we = 0;
  int both_ack = 0;
  int model_last = 1;
  logic [12:0] last_cga_addr = '0;
  logic [7:0]  last_cga_data = '0;

  logic [7:0] mem_arr [0:262143];
  logic [7:0] ref_mem [0:262143];
  logic [7:0] cga_arr [0:8191];
  logic [7:0] ref_cga [0:8191];
  logic [7:0] bios_arr [0:8191];
  logic [19:0] unmapped_list [6] = '{20'h40000, 20'hB7FFF, 20'hBA000, 20'hC0000, 20'hEFFFF, 20'hF2000};

  bus_arbiter #(.BIOS_WP(BIOS_WP_TB)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_address(m0_address), .m0_wdata(m0_wdata), .m0_we(m0_we),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_address(m1_address), .m1_wdata(m1_wdata), .m1_we(m1_we),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_address(mem_address), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q),
    .cga_address(cga_address), .cga_data(cga_data), .cga_we(cga_we), .cga_q(cga_q),
    .bios_address(bios_address), .bios_q(bios_q)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    mem_q  <= mem_arr[mem_address];
    cga_q  <= cga_arr[cga_address];
    bios_q <= bios_arr[bios_address];
    if (mem_we) begin
      mem_arr[mem_address] = mem_data;
      n_mem_we++;
    end
    if (cga_we) begin
      cga_arr[cga_address] = cga_data;
      n_cga_we++;
      last_cga_addr = cga_address;
      last_cga_data = cga_data;
    end
  end

  always @(negedge clock) if (m0_ack && m1_ack) both_ack++;

  function automatic int region_of(input logic [19:0] a);
    if (a < 20'h40000) return 0;
    if (a >= 20'hB8000 && a <= 20'hB9FFF) return 1;
    if (a >= 20'hF0000 && a <= 20'hF1FFF) return 2;
    return 3;
  endfunction

  function automatic logic [19:0] rand_addr();
    case ($urandom_range(0, 5))
      0: return 20'($urandom_range(0, 15));
      1: return 20'h3FFF0 + 20'($urandom_range(0, 15));
      2: return 20'hB8000 + 20'($urandom_range(0, 15));
      3: return 20'hB9FF8 + 20'($urandom_range(0, 7));
      4: return ($urandom_range(0, 1) == 1 ? 20'hF1FF0 : 20'hF0000) + 20'($urandom_range(0, 15));
      default: return unmapped_list[$urandom_range(0, 5)];
    endcase
  endfunction

  task automatic drive(input int m, input logic req, input logic [19:0] a, input logic we, input logic [7:0] d);
    if (m == 0) begin m0_req = req; m0_address = a; m0_we = we; m0_wdata = d; end
    else        begin m1_req = req; m1_address = a; m1_we = we; m1_wdata = d; end
  endtask

  task automatic do_txn(input int m, input logic [19:0] a, input logic we, input logic [7:0] d, input string tag);
    int r, k, mem0, cga0, exp_mw, exp_cw;
    logic exp_err, ack, got_err;
    logic [7:0] exp_rd, got_rd;
    r = region_of(a);
    exp_err = (r == 3) || (we && r == 2 && BIOS_WP_TB);
    exp_rd = 8'hFF;
    if (!we && r == 0) exp_rd = ref_mem[a[17:0]];
    if (!we && r == 1) exp_rd = ref_cga[a[12:0]];
    if (!we && r == 2) exp_rd = bios_arr[a[12:0]];
    exp_mw = (we && r == 0) ? 1 : 0;
    exp_cw = (we && r == 1) ? 1 : 0;
    mem0 = n_mem_we;
    cga0 = n_cga_we;
    @(negedge clock);
    drive(m, 1'b1, a, we, d);
    k = 0;
    ack = 1'b0;
    while (!ack && k < 20) begin
      @(negedge clock);
      k++;
      if (k == 1) begin
        total++;
        if (mem_address !== a[17:0] || cga_address !== a[12:0] || bios_address !== a[12:0]) begin
          bad++;
          $display("FAIL %s access_addr: mem=%h cga=%h bios=%h want %h", tag, mem_address, cga_address, bios_address, a);
        end
        total++;
        if (mem_we !== exp_mw[0] || cga_we !== exp_cw[0]) begin
          bad++;
          $display("FAIL %s access_strobe: mem_we=%b cga_we=%b want %0d %0d", tag, mem_we, cga_we, exp_mw, exp_cw);
        end
        drive(m, 1'b1, 20'($urandom), 1'($urandom), 8'($urandom));
      end
      ack = (m == 0) ? m0_ack : m1_ack;
    end
    total++;
    if (!ack || k != 4) begin
      bad++;
      $display("FAIL %s latency: ack=%b after %0d cycles, want ack=1 after 4", tag, ack, k);
    end
    got_rd  = (m == 0) ? m0_rdata : m1_rdata;
    got_err = (m == 0) ? m0_err : m1_err;
    total++;
    if (got_rd !== exp_rd || got_err !== exp_err) begin
      bad++;
      $display("FAIL %s response: rdata=%h err=%b want rdata=%h err=%b", tag, got_rd, got_err, exp_rd, exp_err);
    end
    drive(m, 1'b0, a, we, d);
    @(negedge clock);
    ack = (m == 0) ? m0_ack : m1_ack;
    total++;
    if (ack !== 1'b0) begin
      bad++;
      $display("FAIL %s ack_drop: ack=%b want 0", tag, ack);
    end
    total++;
    if (n_mem_we - mem0 != exp_mw || n_cga_we - cga0 != exp_cw) begin
      bad++;
      $display("FAIL %s strobe_count: mem=%0d cga=%0d want %0d %0d", tag, n_mem_we - mem0, n_cga_we - cga0, exp_mw, exp_cw);
    end
    if (exp_mw == 1) ref_mem[a[17:0]] = d;
    if (exp_cw == 1) ref_cga[a[12:0]] = d;
    model_last = m;
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    if ({m0_ack, m1_ack, m0_err, m1_err, mem_we, cga_we} !== 6'b0) begin
      bad++;
      $display("FAIL %s flags: ack=%b%b err=%b%b we=%b%b want all 0", tag, m0_ack, m1_ack, m0_err, m1_err, mem_we, cga_we);
    end
    total++;
    if ({m0_rdata, m1_rdata} !== 16'hFFFF) begin
      bad++;
      $display("FAIL %s rdata: %h %h want ff ff", tag, m0_rdata, m1_rdata);
    end
    total++;
    if ({mem_address, cga_address, bios_address, mem_data, cga_data} !== 60'b0) begin
      bad++;
      $display("FAIL %s buses: %h %h %h %h %h want 0", tag, mem_address, cga_address, bios_address, mem_data, cga_data);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    model_last = 1;
  endtask

  task automatic test_directed();
    mem_arr[20'h00010] = 8'h5A;
    ref_mem[20'h00010] = 8'h5A;
    do_txn(0, 20'h00010, 1'b0, 8'h00, "m0_read_mem");
    do_txn(1, 20'hB8002, 1'b1, 8'h41, "m1_write_cga");
    total++;
    if (last_cga_addr !== 13'h0002 || last_cga_data !== 8'h41) begin
      bad++;
      $display("FAIL cga_write_bus: addr=%h data=%h want 0002 41", last_cga_addr, last_cga_data);
    end
    do_txn(0, 20'hF0000, 1'b1, 8'h77, "m0_write_bios");
    do_txn(0, 20'hC0000, 1'b0, 8'h00, "m0_read_unmapped");
    do_txn(1, 20'h40000, 1'b1, 8'h12, "m1_write_unmapped");
  endtask

  task automatic test_round_robin();
    logic [19:0] ra [2];
    int served, got, exp_g;
    logic reraise [2];
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_last = 1;
    ra[0] = 20'($urandom_range(0, 15));
    ra[1] = 20'h3FFF0 + 20'($urandom_range(0, 15));
    reraise[0] = 1'b0;
    reraise[1] = 1'b0;
    drive(0, 1'b1, ra[0], 1'b0, 8'h00);
    drive(1, 1'b1, ra[1], 1'b0, 8'h00);
    served = 0;
    for (int cyc = 0; cyc < 80 && served < 4; cyc++) begin
      @(negedge clock);
      for (int m = 0; m < 2; m++) begin
        if (reraise[m]) begin
          ra[m] = 20'($urandom_range(0, 31));
          drive(m, 1'b1, ra[m], 1'b0, 8'h00);
          reraise[m] = 1'b0;
        end
      end
      got = m0_ack ? 0 : (m1_ack ? 1 : -1);
      if (got >= 0) begin
        exp_g = 1 - model_last;
        model_last = exp_g;
        total++;
        if (got != exp_g || ((got == 0 ? m0_rdata : m1_rdata) !== ref_mem[ra[got][17:0]])) begin
          bad++;
          $display("FAIL rr_grant_%0d: granted m%0d rdata=%h want m%0d rdata=%h", served, got,
                   got == 0 ? m0_rdata : m1_rdata, exp_g, ref_mem[ra[exp_g][17:0]]);
        end
        drive(got, 1'b0, ra[got], 1'b0, 8'h00);
        served++;
        if (served < 4) reraise[got] = 1'b1;
      end
    end
    total++;
    if (served != 4) begin
      bad++;
      $display("FAIL rr_served: %0d grants within budget, want 4", served);
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic test_hold();
    logic [19:0] a0, a1;
    int k;
    a0 = 20'($urandom_range(0, 15));
    a1 = 20'($urandom_range(16, 31));
    @(negedge clock);
    drive(0, 1'b1, a0, 1'b0, 8'h00);
    @(negedge clock);
    drive(1, 1'b1, a1, 1'b0, 8'h00);
    k = 0;
    while (m0_ack !== 1'b1 && k < 10) begin @(negedge clock); k++; end
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      total++;
      if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || m0_rdata !== ref_mem[a0[17:0]]) begin
        bad++;
        $display("FAIL hold_%0d: m0_ack=%b m1_ack=%b m0_rdata=%h want 1 0 %h", i, m0_ack, m1_ack, m0_rdata, ref_mem[a0[17:0]]);
      end
    end
    m0_req = 1'b0;
    k = 0;
    while (m1_ack !== 1'b1 && k < 10) begin @(negedge clock); k++; end
    total++;
    if (m1_ack !== 1'b1 || m1_rdata !== ref_mem[a1[17:0]]) begin
      bad++;
      $display("FAIL hold_pending_m1: ack=%b rdata=%h want 1 %h", m1_ack, m1_rdata, ref_mem[a1[17:0]]);
    end
    m1_req = 1'b0;
    @(negedge clock);
    model_last = 1;
  endtask

  task automatic test_reset_mid();
    int seen, mem0;
    @(negedge clock);
    drive(1, 1'b1, 20'($urandom_range(0, 15)), 1'b0, 8'h00);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    m1_req = 1'b0;
    @(negedge clock);
    check_reset_outputs("reset_mid");
    reset = 1'b0;
    model_last = 1;
    seen = 0;
    repeat (6) begin @(negedge clock); if (m1_ack !== 1'b0) seen++; end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL reset_mid_no_ack: m1_ack seen %0d cycles want 0", seen);
    end
    mem0 = n_mem_we;
    drive(0, 1'b1, 20'h00020, 1'b1, 8'hAA);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    m0_req = 1'b0;
    repeat (3) @(negedge clock);
    total++;
    if (n_mem_we != mem0) begin
      bad++;
      $display("FAIL reset_before_access: %0d strobes want 0", n_mem_we - mem0);
    end
    do_txn(0, 20'($urandom_range(0, 15)), 1'b0, 8'h00, "after_reset_m0");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      do_txn($urandom_range(0, 1), rand_addr(), 1'($urandom_range(0, 1)), 8'($urandom), "random");
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) begin
      mem_arr[i] = 8'($urandom);
      ref_mem[i] = mem_arr[i];
    end
    for (int i = 0; i < 8192; i++) begin
      cga_arr[i]  = 8'($urandom);
      ref_cga[i]  = cga_arr[i];
      bios_arr[i] = 8'($urandom);
    end
    test_reset();
    test_directed();
    test_round_robin();
    test_hold();
    test_reset_mid();
    test_random();
    total++;
    if (both_ack != 0) begin
      bad++;
      $display("FAIL exclusive_ack: both acks high in %0d cycles want 0", both_ack);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
